// File: rtl/cam_deserializer.sv
// cam_deserializer: ESP32 camera-port nibble link receiver; 10-nibble packets -> 32-bit words (CAM_DESERIALIZER_STATS_EN adds counters).
// Latency: valid_o rises SYNC_STAGES+2 clk_i cycles after the sync-nibble pclk rise at the pin.
// Backpressure: none toward the link; an unconsumed word is overwritten (last wins) and overrun_o is set.
module cam_deserializer #(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int TO_WIDTH     = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cam_pclk,
    input  logic        cam_sync,
    input  logic [3:0]  cam_data,
    output logic [31:0] word_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        frame_err_o,
    output logic        overrun_o,
    input  logic        clr_i
`ifdef CAM_DESERIALIZER_STATS_EN
    ,
    output logic [15:0] pkt_count_o,
    output logic [15:0] err_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_DATA,
        ST_SYNC,
        ST_PAD
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(IDLE_TIMEOUT);
    localparam logic [TO_WIDTH-1:0] TO_PRE = TO_WIDTH'(IDLE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0]      pclk_sr;
    logic [SYNC_STAGES-1:0]      sync_sr;
    logic [SYNC_STAGES-1:0][3:0] data_sr;
    logic                        pclk_prev;

    logic                        pclk_s;
    logic                        sync_s;
    logic [3:0]                  data_s;
    logic                        rise;

    logic [TO_WIDTH-1:0]         idle_cnt;
    logic                        timeout;

    state_t                      state;
    state_t                      state_n;
    logic [2:0]                  nib_cnt;
    logic [31:0]                 shreg;
    logic                        deliver_pend;

    logic                        shift;
    logic                        nib_inc;
    logic                        nib_clr;
    logic                        err_set;
    logic                        deliver;

    // All three inputs share one depth so nibble/sync stay aligned with pclk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pclk_sr   <= '0;
            sync_sr   <= '0;
            data_sr   <= '0;
            pclk_prev <= 1'b0;
        end else begin
            pclk_sr[0] <= cam_pclk;
            sync_sr[0] <= cam_sync;
            data_sr[0] <= cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pclk_sr[i] <= pclk_sr[i-1];
                sync_sr[i] <= sync_sr[i-1];
                data_sr[i] <= data_sr[i-1];
            end
            pclk_prev <= pclk_sr[SYNC_STAGES-1];
        end
    end

    assign pclk_s = pclk_sr[SYNC_STAGES-1];
    assign sync_s = sync_sr[SYNC_STAGES-1];
    assign data_s = data_sr[SYNC_STAGES-1];
    assign rise   = pclk_s & ~pclk_prev;

    // One-cycle timeout event on the transition into saturation.
    assign timeout = ~rise && (idle_cnt == TO_PRE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt <= '0;
        end else if (rise) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TO_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        shift   = 1'b0;
        nib_inc = 1'b0;
        nib_clr = 1'b0;
        err_set = 1'b0;
        deliver = 1'b0;
        case (state)
            ST_HUNT: begin
                if (rise && sync_s) begin
                    state_n = ST_PAD;
                end else if (timeout) begin
                    state_n = ST_DATA;
                    nib_clr = 1'b1;
                end
            end
            ST_DATA: begin
                if (rise) begin
                    if (sync_s) begin
                        err_set = 1'b1;
                        state_n = ST_PAD;
                    end else begin
                        shift   = 1'b1;
                        nib_inc = 1'b1;
                        if (nib_cnt == 3'd7) begin
                            state_n = ST_SYNC;
                        end
                    end
                end else if (timeout && (nib_cnt != 3'd0)) begin
                    err_set = 1'b1;
                    nib_clr = 1'b1;
                end
            end
            ST_SYNC: begin
                if (rise) begin
                    if (sync_s) begin
                        deliver = 1'b1;
                        state_n = ST_PAD;
                    end else begin
                        err_set = 1'b1;
                        state_n = ST_HUNT;
                    end
                end else if (timeout) begin
                    err_set = 1'b1;
                    nib_clr = 1'b1;
                    state_n = ST_DATA;
                end
            end
            ST_PAD: begin
                if (rise) begin
                    if (sync_s) begin
                        err_set = 1'b1;
                    end else begin
                        nib_clr = 1'b1;
                        state_n = ST_DATA;
                    end
                end else if (timeout) begin
                    err_set = 1'b1;
                    nib_clr = 1'b1;
                    state_n = ST_DATA;
                end
            end
            default: state_n = ST_HUNT;
        endcase
    end

    // nib_cnt wraps 7->0 on the eighth shift, leaving it ready for the next packet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nib_cnt      <= 3'd0;
            shreg        <= 32'd0;
            deliver_pend <= 1'b0;
        end else begin
            if (nib_clr) begin
                nib_cnt <= 3'd0;
            end else if (nib_inc) begin
                nib_cnt <= nib_cnt + 3'd1;
            end
            if (shift) begin
                shreg <= {data_s, shreg[31:4]};
            end
            deliver_pend <= deliver;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_o      <= 32'd0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (deliver_pend) begin
                word_o  <= shreg;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            if (deliver_pend && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else if (clr_i) begin
                overrun_o <= 1'b0;
            end

            if (err_set) begin
                frame_err_o <= 1'b1;
            end else if (clr_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

`ifdef CAM_DESERIALIZER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_count_o <= 16'd0;
            err_count_o <= 16'd0;
        end else begin
            if (deliver_pend) begin
                pkt_count_o <= pkt_count_o + 16'd1;
            end
            if (err_set) begin
                err_count_o <= err_count_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_deserializer.sv
// Bench for cam_deserializer: random link timing and payloads, scoreboard of expected words and flags.
module tb_cam_deserializer;

    localparam int SYNC_STAGES  = 2;
    localparam int IDLE_TIMEOUT = 16;

    logic        clk;
    logic        rst_i;
    logic        cam_pclk;
    logic        cam_sync;
    logic [3:0]  cam_data;
    logic [31:0] word_o;
    logic        valid_o;
    logic        ready_i;
    logic        frame_err_o;
    logic        overrun_o;
    logic        clr_i;
`ifdef CAM_DESERIALIZER_STATS_EN
    logic [15:0] pkt_count_o;
    logic [15:0] err_count_o;
`endif

    int          nvec = 0;
    int          nerr = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] rx_q[$];

    cam_deserializer #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .cam_pclk   (cam_pclk),
        .cam_sync   (cam_sync),
        .cam_data   (cam_data),
        .word_o     (word_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .clr_i      (clr_i)
`ifdef CAM_DESERIALIZER_STATS_EN
        ,
        .pkt_count_o(pkt_count_o),
        .err_count_o(err_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accepted words as the consumer sees them.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i) rx_q.push_back(word_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send_nibble(input logic [3:0] nib, input logic s);
        int lo = int'($urandom_range(2, 4));
        int hi = int'($urandom_range(2, 4));
        cam_data = nib;
        cam_sync = s;
        repeat (lo) tick();
        cam_pclk = 1'b1;
        repeat (hi) tick();
        cam_pclk = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] w);
        for (int i = 0; i < 8; i++) send_nibble(w[4*i +: 4], 1'b0);
        send_nibble(4'($urandom), 1'b1);
        send_nibble(4'($urandom), 1'b0);
    endtask

    task automatic idle();
        repeat (IDLE_TIMEOUT + SYNC_STAGES + 10) tick();
    endtask

    task automatic drain();
        rand_ready = 1'b0;
        ready_i    = 1'b1;
        repeat (12) tick();
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        nvec++; if (word_o !== 32'd0) begin nerr++; $display("FAIL reset_word: got %h expected 0", word_o); end
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        nvec++; if (overrun_o !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
`ifdef CAM_DESERIALIZER_STATS_EN
        nvec++; if (pkt_count_o !== 16'd0) begin nerr++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count_o); end
        nvec++; if (err_count_o !== 16'd0) begin nerr++; $display("FAIL reset_err_count: got %0d expected 0", err_count_o); end
`endif
        rst_i = 1'b0;
        idle();
    endtask

    task automatic test_single();
        logic [31:0] w = 32'hDEADBEEF;
        int lat = 0;
        exp_q.push_back(w);
        for (int i = 0; i < 8; i++) send_nibble(w[4*i +: 4], 1'b0);
        cam_data = 4'($urandom);
        cam_sync = 1'b1;
        repeat (2) tick();
        cam_pclk = 1'b1;
        while (valid_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        cam_pclk = 1'b0;
        send_nibble(4'($urandom), 1'b0);
        drain();
        nvec++;
        if (lat < SYNC_STAGES + 1 || lat > SYNC_STAGES + 3) begin
            nerr++; $display("FAIL single_latency: got %0d cycles expected %0d..%0d", lat, SYNC_STAGES + 1, SYNC_STAGES + 3);
        end
        nvec++; if (rx_q.size() != 1) begin nerr++; $display("FAIL single_count: got %0d words expected 1", rx_q.size()); end
        else begin
            nvec++; if (rx_q[0] !== w) begin nerr++; $display("FAIL single_word: got %h expected %h", rx_q[0], w); end
        end
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL single_frame_err: got %b expected 0", frame_err_o); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h9ABCDEF0);
        send_packet(32'h12345678);
        send_packet(32'h9ABCDEF0);
        rand_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_packet(w);
        end
        drain();
        nvec++;
        if (rx_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL b2b_count: got %0d words expected %0d", rx_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                nvec++;
                if (rx_q[k] !== exp_q[k]) begin nerr++; $display("FAIL b2b_word[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]); end
            end
        end
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL b2b_frame_err: got %b expected 0", frame_err_o); end
        nvec++; if (overrun_o !== 1'b0) begin nerr++; $display("FAIL b2b_overrun: got %b expected 0", overrun_o); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        send_packet(32'h11111111);
        send_packet(32'h22222222);
        repeat (8) tick();
        nvec++; if (word_o !== 32'h22222222) begin nerr++; $display("FAIL bp_word: got %h expected 22222222", word_o); end
        nvec++; if (valid_o !== 1'b1) begin nerr++; $display("FAIL bp_valid: got %b expected 1", valid_o); end
        nvec++; if (overrun_o !== 1'b1) begin nerr++; $display("FAIL bp_overrun: got %b expected 1", overrun_o); end
        exp_q.push_back(32'h22222222);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        tick();
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL bp_valid_after_accept: got %b expected 0", valid_o); end
        nvec++; if (word_o !== 32'h22222222) begin nerr++; $display("FAIL bp_word_hold: got %h expected 22222222", word_o); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        nvec++; if (overrun_o !== 1'b0) begin nerr++; $display("FAIL bp_overrun_clr: got %b expected 0", overrun_o); end
        nvec++; if (rx_q.size() != 1) begin nerr++; $display("FAIL bp_count: got %0d words expected 1", rx_q.size()); end
        else begin
            nvec++; if (rx_q[0] !== exp_q[0]) begin nerr++; $display("FAIL bp_accepted: got %h expected %h", rx_q[0], exp_q[0]); end
        end
        ready_i = 1'b1;
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_framing();
        logic [31:0] w = $urandom;
        for (int i = 0; i < 5; i++) send_nibble(w[4*i +: 4], 1'b0);
        send_nibble(w[23:20], 1'b1);
        send_nibble(4'($urandom), 1'b0);
        repeat (6) tick();
        nvec++; if (frame_err_o !== 1'b1) begin nerr++; $display("FAIL frm_err_set: got %b expected 1", frame_err_o); end
        nvec++; if (rx_q.size() != 0) begin nerr++; $display("FAIL frm_no_word: got %0d words expected 0", rx_q.size()); end
        exp_q.push_back(32'hCAFEF00D);
        send_packet(32'hCAFEF00D);
        drain();
        nvec++; if (rx_q.size() != 1) begin nerr++; $display("FAIL frm_recover_count: got %0d words expected 1", rx_q.size()); end
        else begin
            nvec++; if (rx_q[0] !== exp_q[0]) begin nerr++; $display("FAIL frm_recover_word: got %h expected %h", rx_q[0], exp_q[0]); end
        end
        nvec++; if (frame_err_o !== 1'b1) begin nerr++; $display("FAIL frm_sticky: got %b expected 1", frame_err_o); end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        tick();
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL frm_clr: got %b expected 0", frame_err_o); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w = 32'hAAAA5555;
        for (int i = 0; i < 4; i++) send_nibble(w[4*i +: 4], 1'b0);
        pulse_reset();
        for (int i = 4; i < 8; i++) send_nibble(w[4*i +: 4], 1'b0);
        send_nibble(4'($urandom), 1'b1);
        send_nibble(4'($urandom), 1'b0);
        repeat (6) tick();
        nvec++; if (rx_q.size() != 0) begin nerr++; $display("FAIL rstmid_no_word: got %0d words expected 0", rx_q.size()); end
        nvec++; if (valid_o !== 1'b0) begin nerr++; $display("FAIL rstmid_valid: got %b expected 0", valid_o); end
        nvec++; if (frame_err_o !== 1'b0) begin nerr++; $display("FAIL rstmid_frame_err: got %b expected 0", frame_err_o); end
        idle();
        exp_q.push_back(32'h0F0F0F0F);
        send_packet(32'h0F0F0F0F);
        drain();
        nvec++; if (rx_q.size() != 1) begin nerr++; $display("FAIL rstmid_count: got %0d words expected 1", rx_q.size()); end
        else begin
            nvec++; if (rx_q[0] !== exp_q[0]) begin nerr++; $display("FAIL rstmid_word: got %h expected %h", rx_q[0], exp_q[0]); end
        end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_truncation();
        logic [31:0] w = $urandom;
        pulse_reset();
        idle();
        for (int i = 0; i < 5; i++) send_nibble(w[4*i +: 4], 1'b0);
        idle();
        nvec++; if (frame_err_o !== 1'b1) begin nerr++; $display("FAIL trunc_frame_err: got %b expected 1", frame_err_o); end
        nvec++; if (rx_q.size() != 0) begin nerr++; $display("FAIL trunc_no_word: got %0d words expected 0", rx_q.size()); end
        exp_q.push_back(32'h13579BDF);
        send_packet(32'h13579BDF);
        drain();
        nvec++; if (rx_q.size() != 1) begin nerr++; $display("FAIL trunc_count: got %0d words expected 1", rx_q.size()); end
        else begin
            nvec++; if (rx_q[0] !== exp_q[0]) begin nerr++; $display("FAIL trunc_word: got %h expected %h", rx_q[0], exp_q[0]); end
        end
`ifdef CAM_DESERIALIZER_STATS_EN
        nvec++; if (pkt_count_o !== 16'd1) begin nerr++; $display("FAIL trunc_pkt_count: got %0d expected 1", pkt_count_o); end
        nvec++; if (err_count_o !== 16'd1) begin nerr++; $display("FAIL trunc_err_count: got %0d expected 1", err_count_o); end
`endif
        rx_q.delete(); exp_q.delete();
    endtask

    initial begin
        rst_i    = 1'b1;
        cam_pclk = 1'b0;
        cam_sync = 1'b0;
        cam_data = 4'd0;
        ready_i  = 1'b1;
        clr_i    = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_framing();
        test_reset_mid();
        test_truncation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cam_deserializer.md
Name: cam_deserializer

Overview:
- Receive side of the ESP32 camera-port nibble link.
- Oversamples cam_pclk, cam_sync and cam_data in the clk_i domain and reassembles each 10-nibble packet into one 32-bit word: 8 data nibbles LSN-first, a sync nibble, then a pad nibble.
- Presents words on a valid/ready interface with a 1-deep holding register.
- Flags framing errors and overruns with sticky status bits.

Parameters:
- SYNC_STAGES, 2: synchroniser depth for cam_pclk, cam_sync and cam_data, all with identical depth.
- IDLE_TIMEOUT, 16: number of clk_i cycles without a pclk rising edge that counts as link idle.
- TO_WIDTH, $clog2(IDLE_TIMEOUT+1): width of the idle counter (derived).

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous active-high reset
- cam_pclk  input  1  link clock; gated low when idle
- cam_sync  input  1  high during nibble 8 of a packet
- cam_data  input  4  nibble bus; changes on pclk falling edge
- word_o  output  32  received word
- valid_o  output  1  word_o holds an unconsumed word
- ready_i  input  1  consumer accepts word_o when valid_o && ready_i
- frame_err_o  output  1  sticky framing-error flag
- overrun_o  output  1  sticky flag: a word was overwritten before it was consumed
- clr_i  input  1  clears frame_err_o and overrun_o

Behaviour:
- Clocking requirement: cam_pclk high and low phases are each at least 2 clk_i cycles (COUNT_WIDTH>=2 at the source).
- Input path: all three inputs pass through SYNC_STAGES flops, plus one extra pclk flop for edge detection.
- Sampling: a rise = synced pclk 1 with previous 0. Nibble and sync are sampled on the rise, from the same pipeline stage as pclk.
- Idle counter: cleared on every rise; otherwise increments and saturates at IDLE_TIMEOUT. A timeout event fires when it reaches IDLE_TIMEOUT.
- Assembly: shreg <= {nibble, shreg[31:4]}. After 8 nibbles, shreg[3:0] holds the first nibble received.
- nib_cnt is 3 bits, counting 0..7.
- State machine (reset -> HUNT):
  - HUNT: on a rise with sync=1 -> PAD. On timeout -> DATA with nib_cnt=0. Other rises are ignored.
  - DATA: on a rise with sync=0, shift and increment; when nib_cnt reaches 7 and is shifted -> SYNC. On a rise with sync=1 -> set frame_err_o, discard the word, go to PAD. On timeout with nib_cnt!=0 -> set frame_err_o, nib_cnt=0. On timeout with nib_cnt=0, no action.
  - SYNC: on a rise with sync=1 -> deliver shreg, go to PAD. On a rise with sync=0 -> set frame_err_o, go to HUNT. On timeout -> set frame_err_o, go to DATA with nib_cnt=0.
  - PAD: on a rise with sync=0 -> DATA with nib_cnt=0; the pad nibble is not shifted. On a rise with sync=1 -> set frame_err_o, stay in PAD. On timeout -> set frame_err_o, go to DATA with nib_cnt=0.
- Back-to-back packets: the rise after the pad rise is nibble 0 of the next packet. No idle gap is required.
- Delivery: on the cycle after the sync rise, word_o <= shreg and valid_o <= 1.
  - If valid_o=1 and ready_i=0 on the delivery cycle: the new word overwrites word_o (last word wins), overrun_o <= 1, valid_o stays 1.
  - Handshake and delivery in the same cycle: the new word is loaded, valid_o stays 1, no overrun.
- Handshake: when valid_o && ready_i and there is no delivery that cycle, valid_o <= 0. word_o holds its value.
- Latency: valid_o rises SYNC_STAGES+2 clk_i cycles after the sync-nibble pclk rise at the pin (±1 for sampling phase).
- Sticky flags: cleared by clr_i. If a set and clr_i occur in the same cycle, set wins.
- Reset values: word_o=0, valid_o=0, frame_err_o=0, overrun_o=0, state=HUNT, nib_cnt=0, shreg=0, idle counter=0, synchronisers=0.
- Reset mid-packet: the partial word is discarded. The receiver realigns via HUNT on the next sync or timeout, and no valid_o is produced for the cut packet.

Optional Feature:
- Macro: CAM_DESERIALIZER_STATS_EN.
- Defined: adds outputs pkt_count_o[15:0] (words delivered) and err_count_o[15:0] (frame_err set events). Both wrap at 16 bits, reset to 0 on rst_i, and are not affected by clr_i.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Single word: after the link has been idle >IDLE_TIMEOUT, send 0xDEADBEEF with ready_i=1 -> one valid_o pulse, word_o=0xDEADBEEF, frame_err_o=0.
- Back-to-back: send 0x12345678 then 0x9ABCDEF0 with no pclk gap, ready_i=1 -> two accepted words in that order, no errors.
- Backpressure: ready_i=0, send 0x11111111 then 0x22222222 -> word_o=0x22222222, valid_o=1, overrun_o=1. Then ready_i=1 for one cycle -> valid_o=0. Then clr_i -> overrun_o=0.
- Framing error: assert cam_sync on nibble 5 -> frame_err_o=1 with no valid_o. The following good packet 0xCAFEF00D is delivered correctly.
- Reset mid-packet: pulse rst_i after nibble 3 of 0xAAAA5555 -> no valid_o for it. After idle, 0x0F0F0F0F is received correctly.
- Truncation: stop pclk after nibble 4 for >IDLE_TIMEOUT -> frame_err_o=1. The next full packet 0x13579BDF is received. With CAM_DESERIALIZER_STATS_EN defined: pkt_count_o=1, err_count_o=1.
